// File: rtl/optflow_pkg.sv
// optflow_pkg: shared widths, product/sum bundles and sign-extending adders
// for the Lucas-Kanade structure-tensor datapath.
package optflow_pkg;

    localparam int GRAD_WIDTH = 12;
    localparam int PROD_WIDTH = 2 * GRAD_WIDTH;
    localparam int ACC_WIDTH  = PROD_WIDTH + 4;

    typedef struct packed {
        logic signed [PROD_WIDTH-1:0] ixx;
        logic signed [PROD_WIDTH-1:0] iyy;
        logic signed [PROD_WIDTH-1:0] ixy;
        logic signed [PROD_WIDTH-1:0] ixt;
        logic signed [PROD_WIDTH-1:0] iyt;
    } tensor_prod_t;

    typedef struct packed {
        logic signed [ACC_WIDTH-1:0] ixx;
        logic signed [ACC_WIDTH-1:0] iyy;
        logic signed [ACC_WIDTH-1:0] ixy;
        logic signed [ACC_WIDTH-1:0] ixt;
        logic signed [ACC_WIDTH-1:0] iyt;
    } tensor_sum_t;

    function automatic logic signed [ACC_WIDTH-1:0] sx(input logic signed [PROD_WIDTH-1:0] v);
        return ACC_WIDTH'(v);
    endfunction

    // Vertical 3-pixel sum of products, widened before adding.
    function automatic tensor_sum_t col_sum(input tensor_prod_t a, input tensor_prod_t b,
                                            input tensor_prod_t c);
        tensor_sum_t s;
        s.ixx = sx(a.ixx) + sx(b.ixx) + sx(c.ixx);
        s.iyy = sx(a.iyy) + sx(b.iyy) + sx(c.iyy);
        s.ixy = sx(a.ixy) + sx(b.ixy) + sx(c.ixy);
        s.ixt = sx(a.ixt) + sx(b.ixt) + sx(c.ixt);
        s.iyt = sx(a.iyt) + sx(b.iyt) + sx(c.iyt);
        return s;
    endfunction

    function automatic tensor_sum_t add3(input tensor_sum_t a, input tensor_sum_t b,
                                         input tensor_sum_t c);
        tensor_sum_t s;
        s.ixx = a.ixx + b.ixx + c.ixx;
        s.iyy = a.iyy + b.iyy + c.iyy;
        s.ixy = a.ixy + b.ixy + c.ixy;
        s.ixt = a.ixt + b.ixt + c.ixt;
        s.iyt = a.iyt + b.iyt + c.iyt;
        return s;
    endfunction

endpackage

// File: rtl/tensor_row_buffer.sv
// tensor_row_buffer: two chained line delays of product bundles sharing one
// address; a write pushes the previous line down, reads return pre-write data.
//   clk   : clock
//   en    : advance (write) at addr
//   addr  : column address
//   wr    : product bundle entering line 1
//   rd1   : same column, one line back
//   rd2   : same column, two lines back
module tensor_row_buffer
    import optflow_pkg::*;
#(
    parameter int DEPTH = 320,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clk,
    input  logic         en,
    input  logic [AW-1:0] addr,
    input  tensor_prod_t wr,
    output tensor_prod_t rd1,
    output tensor_prod_t rd2
);

    tensor_prod_t mem1 [DEPTH];
    tensor_prod_t mem2 [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            mem2[addr] <= mem1[addr];
            mem1[addr] <= wr;
        end
    end

    assign rd1 = mem1[addr];
    assign rd2 = mem2[addr];

endmodule

// File: rtl/structure_tensor_window.sv
// structure_tensor_window: 3x3 sliding-window sums of Ix^2, Iy^2, IxIy, IxIt,
// IyIt over a raster gradient stream, fixed 3-cycle latency, no backpressure.
//   clk, rst_n            : clock, asynchronous active-low reset
//   grad_x/y/t, grad_valid: signed gradient beat and qualifier
//   sum_ixx..sum_iyt      : signed window sums
//   tensor_valid          : window complete (row >= 2 and col >= 2)
//   tensor_last           : final window of the frame
module structure_tensor_window
    import optflow_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [GRAD_WIDTH-1:0] grad_x,
    input  logic signed [GRAD_WIDTH-1:0] grad_y,
    input  logic signed [GRAD_WIDTH-1:0] grad_t,
    input  logic                         grad_valid,
    output logic signed [ACC_WIDTH-1:0]  sum_ixx,
    output logic signed [ACC_WIDTH-1:0]  sum_iyy,
    output logic signed [ACC_WIDTH-1:0]  sum_ixy,
    output logic signed [ACC_WIDTH-1:0]  sum_ixt,
    output logic signed [ACC_WIDTH-1:0]  sum_iyt,
    output logic                         tensor_valid,
    output logic                         tensor_last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic [CW-1:0] col, p_col, s_col;
    logic [RW-1:0] row, p_row, s_row;
    logic          prod_valid, s_valid;
    tensor_prod_t  prod, rd1, rd2;
    tensor_sum_t   cs, tap0, tap1, tap2, out;

    tensor_row_buffer #(.DEPTH(WIDTH), .AW(CW)) u_rb (
        .clk  (clk),
        .en   (prod_valid),
        .addr (p_col),
        .wr   (prod),
        .rd1  (rd1),
        .rd2  (rd2)
    );

    always_comb cs = col_sum(prod, rd1, rd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
            prod <= '0;
            p_col <= '0;
            p_row <= '0;
            prod_valid <= 1'b0;
        end else begin
            prod_valid <= grad_valid;
            if (grad_valid) begin
                prod.ixx <= grad_x * grad_x;
                prod.iyy <= grad_y * grad_y;
                prod.ixy <= grad_x * grad_y;
                prod.ixt <= grad_x * grad_t;
                prod.iyt <= grad_y * grad_t;
                p_col <= col;
                p_row <= row;
                col <= (col == CW'(WIDTH - 1)) ? '0 : col + CW'(1);
                if (col == CW'(WIDTH - 1))
                    row <= (row == RW'(HEIGHT - 1)) ? '0 : row + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap0 <= '0;
            tap1 <= '0;
            tap2 <= '0;
            s_col <= '0;
            s_row <= '0;
            s_valid <= 1'b0;
        end else begin
            s_valid <= prod_valid;
            if (prod_valid) begin
                tap0 <= cs;
                tap1 <= tap0;
                tap2 <= tap1;
                s_col <= p_col;
                s_row <= p_row;
            end
        end
    end

    // Windows touching the left edge or top two rows are dropped, so stale
    // taps and previous-frame lines never reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
            tensor_valid <= 1'b0;
            tensor_last <= 1'b0;
        end else begin
            tensor_valid <= s_valid && s_row >= RW'(2) && s_col >= CW'(2);
            tensor_last <= s_valid && s_row == RW'(HEIGHT - 1) && s_col == CW'(WIDTH - 1);
            if (s_valid && s_row >= RW'(2) && s_col >= CW'(2))
                out <= add3(tap0, tap1, tap2);
        end
    end

    assign sum_ixx = out.ixx;
    assign sum_iyy = out.iyy;
    assign sum_ixy = out.ixy;
    assign sum_ixt = out.ixt;
    assign sum_iyt = out.iyt;

endmodule

// File: tb/tb_structure_tensor_window.sv
// tb_structure_tensor_window: directed checks of window sums, latency, borders,
// gaps, frame wrap and mid-frame reset against a frame-array reference.
module tb_structure_tensor_window;
    import optflow_pkg::*;

    localparam int W = 8;
    localparam int H = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic signed [GRAD_WIDTH-1:0] grad_x = '0, grad_y = '0, grad_t = '0;
    logic grad_valid = 1'b0;
    logic signed [ACC_WIDTH-1:0] sum_ixx, sum_iyy, sum_ixy, sum_ixt, sum_iyt;
    logic tensor_valid, tensor_last;

    structure_tensor_window #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n),
        .grad_x(grad_x), .grad_y(grad_y), .grad_t(grad_t), .grad_valid(grad_valid),
        .sum_ixx(sum_ixx), .sum_iyy(sum_iyy), .sum_ixy(sum_ixy),
        .sum_ixt(sum_ixt), .sum_iyt(sum_iyt),
        .tensor_valid(tensor_valid), .tensor_last(tensor_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     cyc;
        int     r;
        int     c;
        longint ixx, iyy, ixy, ixt, iyt;
        bit     last;
    } exp_t;

    exp_t q[$];
    int gx[H][W], gy[H][W], gt[H][W];
    int cyc = 0;
    int n_cmp = 0, n_err = 0;
    int n_valid = 0, n_last = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (tensor_valid) begin
            n_valid++;
            if (tensor_last) n_last++;
            if (q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("latency", cyc, e.cyc);
                check("ixx", sum_ixx, e.ixx);
                check("iyy", sum_iyy, e.iyy);
                check("ixy", sum_ixy, e.ixy);
                check("ixt", sum_ixt, e.ixt);
                check("iyt", sum_iyt, e.iyt);
                check("last", tensor_last, e.last);
            end
        end else begin
            if (tensor_last) check("last_without_valid", 1, 0);
            if (q.size() != 0 && q[0].cyc < cyc) check("missed_output", 0, 1);
            if (q.size() != 0 && q[0].cyc < cyc) void'(q.pop_front());
        end
    end

    task automatic fill(input int x, input int y, input int t);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                gx[r][c] = x;
                gy[r][c] = y;
                gt[r][c] = t;
            end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            grad_valid = 1'b0;
            grad_x = GRAD_WIDTH'($urandom);
            grad_y = GRAD_WIDTH'($urandom);
            grad_t = GRAD_WIDTH'($urandom);
        end
    endtask

    task automatic send(input int r, input int c, input int gap);
        exp_t e;
        idle(gap);
        @(negedge clk);
        grad_valid = 1'b1;
        grad_x = GRAD_WIDTH'(gx[r][c]);
        grad_y = GRAD_WIDTH'(gy[r][c]);
        grad_t = GRAD_WIDTH'(gt[r][c]);
        if (r >= 2 && c >= 2) begin
            e.cyc = cyc + 3;
            e.r = r;
            e.c = c;
            e.ixx = 0; e.iyy = 0; e.ixy = 0; e.ixt = 0; e.iyt = 0;
            for (int i = r - 2; i <= r; i++)
                for (int j = c - 2; j <= c; j++) begin
                    e.ixx += longint'(gx[i][j]) * gx[i][j];
                    e.iyy += longint'(gy[i][j]) * gy[i][j];
                    e.ixy += longint'(gx[i][j]) * gy[i][j];
                    e.ixt += longint'(gx[i][j]) * gt[i][j];
                    e.iyt += longint'(gy[i][j]) * gt[i][j];
                end
            e.last = (r == H - 1 && c == W - 1);
            q.push_back(e);
        end
    endtask

    task automatic frame(input int maxgap);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send(r, c, maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic finish_test(input string tag, input int nv, input int nl);
        idle(6);
        check({tag, "_count"}, n_valid, nv);
        check({tag, "_lasts"}, n_last, nl);
        check({tag, "_drain"}, q.size(), 0);
        n_valid = 0;
        n_last = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ixx"}, sum_ixx, 0);
        check({tag, "_iyy"}, sum_iyy, 0);
        check({tag, "_ixy"}, sum_ixy, 0);
        check({tag, "_ixt"}, sum_ixt, 0);
        check({tag, "_iyt"}, sum_iyt, 0);
        check({tag, "_valid"}, tensor_valid, 0);
        check({tag, "_last"}, tensor_last, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        fill(1, 2, -3);
        frame(0);
        finish_test("const", 24, 1);
        check("const_hold_ixx", sum_ixx, 9);
        check("const_hold_iyt", sum_iyt, -54);

        fill(-2048, -2048, 2047);
        frame(0);
        finish_test("extreme", 24, 1);
        check("extreme_hold_ixx", sum_ixx, 37748736);
        check("extreme_hold_ixt", sum_ixt, -37730304);

        fill(0, 0, 0);
        gx[3][3] = 4;
        gt[3][3] = 5;
        frame(0);
        finish_test("impulse", 24, 1);

        fill(1, 2, -3);
        frame(3);
        finish_test("gaps", 24, 1);

        fill(7, 0, 0);
        frame(0);
        fill(1, 0, 0);
        frame(0);
        finish_test("wrap", 48, 2);

        fill(1, 2, -3);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (r < 3 || (r == 3 && c <= 4)) send(r, c, 0);
        @(negedge clk);
        grad_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_zero("midreset");
        q.delete();
        n_valid = 0;
        n_last = 0;
        repeat (2) @(negedge clk);
        check_zero("midreset_hold");
        rst_n = 1'b1;
        fill(2, -1, 3);
        frame(0);
        finish_test("after_reset", 24, 1);
        check("after_reset_ixx", sum_ixx, 36);
        check("after_reset_iyt", sum_iyt, -27);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/structure_tensor_window.md
Name: structure_tensor_window

Overview:
- Sits directly downstream of the gradient stage. Consumes the raster stream of signed (Ix, Iy, It) gradient triples.
- Forms five per-pixel products: Ix², Iy², IxIy, IxIt, IyIt.
- Outputs their 3x3 sliding-window sums. These are the Lucas-Kanade structure-tensor and mismatch terms consumed by the downstream flow solver.
- Fixed-latency, valid-qualified stream. No backpressure.

Parameters:
- WIDTH, 320: gradient beats per line.
- HEIGHT, 240: gradient lines per frame.
- GRAD_WIDTH, 12: signed gradient width.
- PROD_WIDTH, 24: signed product width (2*GRAD_WIDTH).
- ACC_WIDTH, 28: signed window-sum width (PROD_WIDTH+4).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- grad_x  in  GRAD_WIDTH  signed Ix
- grad_y  in  GRAD_WIDTH  signed Iy
- grad_t  in  GRAD_WIDTH  signed It
- grad_valid  in  1  input beat qualifier
- sum_ixx  out  ACC_WIDTH  signed 3x3 sum of Ix*Ix
- sum_iyy  out  ACC_WIDTH  signed 3x3 sum of Iy*Iy
- sum_ixy  out  ACC_WIDTH  signed 3x3 sum of Ix*Iy
- sum_ixt  out  ACC_WIDTH  signed 3x3 sum of Ix*It
- sum_iyt  out  ACC_WIDTH  signed 3x3 sum of Iy*It
- tensor_valid  out  1  window sums valid
- tensor_last  out  1  asserted with final window of frame

Behaviour:
- Clocking/reset: one clock, clk. rst_n is asynchronous, active-low. During reset all outputs are 0, counters are 0, and pipeline valids are 0. Row-buffer contents need no reset.
- S1, cycle +1 after an accepted beat: register the five full-precision signed products and the beat's (row, col). Set prod_valid.
- S2, on prod_valid:
  - Read row buffers at col and form column sums: p + rb1[col] + rb2[col].
  - Write rb2[col] <= rb1[col] and rb1[col] <= p. Read-during-write returns the old data.
  - Shift the column sums into a 3-deep horizontal tap register.
  - Carry the tag (row, col) forward.
- S3: register the sum of the 3 horizontal taps into the sum_* outputs.
  - tensor_valid = 1 iff the tagged beat has row >= 2 and col >= 2.
  - tensor_last = 1 iff row == HEIGHT-1 and col == WIDTH-1.
- Latency: exactly 3 clk cycles from the accepted beat completing a window (its bottom-right pixel) to tensor_valid. This holds regardless of gaps in grad_valid.
- Stall behaviour: row buffers, horizontal taps and counters advance only on valid beats. Idle cycles are ignored.
- Counters: col counts 0..WIDTH-1 and increments per accepted beat. At WIDTH-1 it wraps to 0 and row increments. Row wraps to 0 after HEIGHT-1, starting a new frame.
- Output shape: (WIDTH-2)*(HEIGHT-2) valid outputs per frame, and exactly one tensor_last per frame.
- Borders: windows straddling the left edge or top two rows are suppressed, never zero-padded. Stale taps and previous-frame row-buffer data are therefore never visible at the output.
- Idle outputs: when tensor_valid = 0, sum_* hold their last value. tensor_last is only ever 1 together with tensor_valid.
- Arithmetic: all signed, sign-extended to ACC_WIDTH before summing. No saturation is needed, because the worst case 9*2048² is below 2^27.
- Reset mid-frame: the pipeline is flushed with no further outputs, and counters return to 0. The next beat after release is treated as (0,0).

Decomposition:
- optflow_pkg (shared package) holds:
  - Width constants GRAD_WIDTH, PROD_WIDTH and ACC_WIDTH.
  - Typedef tensor_prod_t: a packed struct of the five PROD_WIDTH products.
  - Typedef tensor_sum_t: a packed struct of the five ACC_WIDTH sums.
- Sub-module tensor_row_buffer: dual-row, WIDTH-deep delay storage of tensor_prod_t.
  - Single address, read-old-on-write, advanced by an enable.
  - Maps to BRAM. The top level holds counters, products, taps and outputs.

Test Plan:
1. Constant stream: WIDTH=8, HEIGHT=6, Ix=1, Iy=2, It=-3 every beat, back-to-back.
   - Every output is ixx=9, iyy=36, ixy=18, ixt=-27, iyt=-54.
   - Exactly 24 tensor_valid pulses; tensor_last on the 24th.
   - First valid output 3 cycles after beat (2,2).
2. Extremes: Ix=Iy=-2048, It=2047 everywhere.
   - ixx = iyy = ixy = 37748736.
   - ixt = iyt = -37730304.
   - No wrap.
3. Impulse: Ix=4, It=5 at beat (3,3), all other gradients 0.
   - ixx=16 and ixt=20 exactly at outputs tagged (r,c) with r,c in 3..5; all other outputs 0.
4. Random gaps: case 1 stimulus with randomized grad_valid deassertions.
   - Identical output values and count.
   - Each output exactly 3 cycles after its completing beat.
5. Frame wrap: two back-to-back frames, frame 1 all Ix=7 and frame 2 all Ix=1.
   - Frame 2 outputs all ixx=9; no contamination from frame 1.
   - One tensor_last per frame.
6. Reset mid-frame: assert rst_n=0 at beat (3,4).
   - All outputs 0 immediately (asynchronous).
   - After release, a full frame yields correct sums and exactly 24 valid outputs.
